// File: rtl/viterbi_job_ctrl_if.sv
// Signal bundle between the observation source, the Viterbi core and the
// result consumer. The job controller uses the slave view; the surrounding
// environment uses the master view.
interface viterbi_job_ctrl_if #(
  parameter int CNTW = 16
);
  // observation stream
  logic [1:0]      s_obs;
  logic            s_last;
  logic            s_valid;
  logic            s_ready;
  // decoder core side
  logic            v_start;
  logic [2:0]      v_length;
  logic [1:0]      v_obs_in;
  logic            v_obs_valid;
  logic            v_done;
  logic [15:0]     v_path;
  // result port
  logic [15:0]     m_path;
  logic [2:0]      m_len;
  logic [1:0]      m_flags;
  logic            m_valid;
  logic            m_ready;
  logic [CNTW-1:0] jobs_done;

  modport slave (
    input  s_obs, s_last, s_valid,
    output s_ready,
    output v_start, v_length, v_obs_in, v_obs_valid,
    input  v_done, v_path,
    output m_path, m_len, m_flags, m_valid,
    input  m_ready,
    output jobs_done
  );

  modport master (
    output s_obs, s_last, s_valid,
    input  s_ready,
    input  v_start, v_length, v_obs_in, v_obs_valid,
    output v_done, v_path,
    input  m_path, m_len, m_flags, m_valid,
    output m_ready,
    input  jobs_done
  );
endinterface

// File: rtl/viterbi_job_ctrl.sv
// Job sequencer for the 3-state Viterbi decoder core. A collector FSM buffers
// up to seven observation symbols; a sequencer FSM replays the buffer into the
// core, waits for done, captures the masked path and offers it on the result
// port. Collection of the next job overlaps decoding of the current one.
module viterbi_job_ctrl #(
  parameter int CNTW = 16
) (
  input logic               clk,
  input logic               rst_n,
  viterbi_job_ctrl_if.slave vj
);

  localparam int MAXLEN = 7;

  typedef enum logic [1:0] {
    COL_COLLECT = 2'd0,
    COL_FULL    = 2'd1,
    COL_DISCARD = 2'd2
  } col_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } seq_state_t;

  // Keeps only the path entries that belong to a job of length len.
  function automatic logic [15:0] path_mask(input logic [2:0] len);
    logic [15:0] m;
    case (len)
      3'd1:    m = 16'h0003;
      3'd2:    m = 16'h000F;
      3'd3:    m = 16'h003F;
      3'd4:    m = 16'h00FF;
      3'd5:    m = 16'h03FF;
      3'd6:    m = 16'h0FFF;
      3'd7:    m = 16'h3FFF;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // collector state
  col_state_t  r_col_state;
  col_state_t  w_col_next;
  logic [2:0]  r_cnt;
  logic [1:0]  r_buf [MAXLEN];
  logic [2:0]  r_len;
  logic        r_trunc;
  logic        r_bad;
  logic        r_s_ready;

  // sequencer state
  seq_state_t  r_seq_state;
  seq_state_t  w_seq_next;
  logic [2:0]  r_idx;
  logic        r_release;
  logic [1:0]  r_job_flags;
  logic        r_v_start;
  logic [2:0]  r_v_length;
  logic [1:0]  r_v_obs_in;
  logic        r_v_obs_valid;
  logic [15:0] r_m_path;
  logic [2:0]  r_m_len;
  logic [1:0]  r_m_flags;
  logic        r_m_valid;
  logic [CNTW-1:0] r_jobs_done;

  logic        w_s_hs;
  logic [1:0]  w_sym;
  logic        w_bad_sym;
  logic        w_cnt_max;
  logic        w_issue;
  logic        w_feed_last;

  assign w_s_hs      = vj.s_valid && r_s_ready;
  assign w_bad_sym   = (vj.s_obs == 2'd3);
  assign w_sym       = w_bad_sym ? 2'd0 : vj.s_obs;
  assign w_cnt_max   = (r_cnt == 3'(MAXLEN - 1));
  // the sequencer only looks at the registered m_valid, so a start never
  // coincides with the result handshake
  assign w_issue     = (r_col_state == COL_FULL) && !r_m_valid && !vj.v_done;
  assign w_feed_last = (r_idx == (r_v_length - 3'd1));

  // Collector next-state: fill, overflow into discard, hold while full.
  always_comb begin
    w_col_next = r_col_state;
    case (r_col_state)
      COL_COLLECT: begin
        if (w_s_hs && vj.s_last) begin
          w_col_next = COL_FULL;
        end else if (w_s_hs && w_cnt_max) begin
          w_col_next = COL_DISCARD;
        end else begin
          w_col_next = COL_COLLECT;
        end
      end
      COL_DISCARD: begin
        if (w_s_hs && vj.s_last) begin
          w_col_next = COL_FULL;
        end else begin
          w_col_next = COL_DISCARD;
        end
      end
      COL_FULL: begin
        if (r_release) begin
          w_col_next = COL_COLLECT;
        end else begin
          w_col_next = COL_FULL;
        end
      end
      default: w_col_next = COL_COLLECT;
    endcase
  end

  // Collector registers: symbol buffer, count, length and job flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_state <= COL_COLLECT;
      r_cnt       <= 3'd0;
      r_buf       <= '{default: 2'b00};
      r_len       <= 3'd0;
      r_trunc     <= 1'b0;
      r_bad       <= 1'b0;
      r_s_ready   <= 1'b1;
    end else begin
      r_col_state <= w_col_next;
      r_s_ready   <= (w_col_next != COL_FULL);
      case (r_col_state)
        COL_COLLECT: begin
          if (w_s_hs) begin
            r_buf[r_cnt] <= w_sym;
            r_bad        <= r_bad | w_bad_sym;
            if (vj.s_last) begin
              r_len <= r_cnt + 3'd1;
            end else if (w_cnt_max) begin
              r_trunc <= 1'b1;
              r_len   <= 3'(MAXLEN);
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        COL_FULL: begin
          if (r_release) begin
            r_cnt   <= 3'd0;
            r_trunc <= 1'b0;
            r_bad   <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Sequencer next-state: issue, feed remaining symbols, wait, drain done.
  always_comb begin
    w_seq_next = r_seq_state;
    case (r_seq_state)
      S_IDLE: begin
        if (w_issue) begin
          w_seq_next = (r_len == 3'd1) ? S_WAIT : S_FEED;
        end else begin
          w_seq_next = S_IDLE;
        end
      end
      S_FEED: begin
        if (w_feed_last) begin
          w_seq_next = S_WAIT;
        end else begin
          w_seq_next = S_FEED;
        end
      end
      S_WAIT: begin
        if (vj.v_done) begin
          w_seq_next = S_DRAIN;
        end else begin
          w_seq_next = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (!vj.v_done) begin
          w_seq_next = S_IDLE;
        end else begin
          w_seq_next = S_DRAIN;
        end
      end
      default: w_seq_next = S_IDLE;
    endcase
  end

  // Sequencer registers: core drive pulses, buffer release and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_state   <= S_IDLE;
      r_idx         <= 3'd0;
      r_release     <= 1'b0;
      r_job_flags   <= 2'b00;
      r_v_start     <= 1'b0;
      r_v_length    <= 3'd0;
      r_v_obs_in    <= 2'd0;
      r_v_obs_valid <= 1'b0;
      r_m_path      <= 16'h0000;
      r_m_len       <= 3'd0;
      r_m_flags     <= 2'b00;
      r_m_valid     <= 1'b0;
      r_jobs_done   <= {CNTW{1'b0}};
    end else begin
      r_seq_state   <= w_seq_next;
      r_v_start     <= 1'b0;
      r_v_obs_valid <= 1'b0;
      r_release     <= 1'b0;
      if (r_m_valid && vj.m_ready) begin
        r_m_valid <= 1'b0;
      end
      case (r_seq_state)
        S_IDLE: begin
          if (w_issue) begin
            r_v_start   <= 1'b1;
            r_v_obs_in  <= r_buf[0];
            r_v_length  <= r_len;
            r_job_flags <= {r_bad, r_trunc};
            r_idx       <= 3'd1;
            r_release   <= (r_len == 3'd1);
          end
        end
        S_FEED: begin
          r_v_obs_valid <= 1'b1;
          r_v_obs_in    <= r_buf[r_idx];
          r_idx         <= r_idx + 3'd1;
          r_release     <= w_feed_last;
        end
        S_WAIT: begin
          if (vj.v_done) begin
            r_m_path    <= vj.v_path & path_mask(r_v_length);
            r_m_len     <= r_v_length;
            r_m_flags   <= r_job_flags;
            r_m_valid   <= 1'b1;
            r_jobs_done <= r_jobs_done + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign vj.s_ready     = r_s_ready;
  assign vj.v_start     = r_v_start;
  assign vj.v_length    = r_v_length;
  assign vj.v_obs_in    = r_v_obs_in;
  assign vj.v_obs_valid = r_v_obs_valid;
  assign vj.m_path      = r_m_path;
  assign vj.m_len       = r_m_len;
  assign vj.m_flags     = r_m_flags;
  assign vj.m_valid     = r_m_valid;
  assign vj.jobs_done   = r_jobs_done;

endmodule

// File: doc/viterbi_job_ctrl.md
# viterbi_job_ctrl

Job sequencer for the 3-state Viterbi decoder core. It collects an observation stream into a 7-entry symbol buffer and issues the buffered sequence to the core via the core's start/obs_valid protocol. It then waits for the core's done, captures the decoded path and returns it on a valid/ready result port. It sits between the observation source and the decoder core; the HMM matrices are wired directly to the core by the integrator.

## Interface
Parameters:
- MAXLEN, 7, maximum sequence length. Fixed by the core's 3-bit length input; not overridable.
- CNTW, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset. Shared with the core.
- s_obs  in  2  observation symbol.
- s_last  in  1  marks the final symbol of a sequence.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  input symbol accepted when s_valid&&s_ready.
- v_start  out  1  to core start. Registered.
- v_length  out  3  to core length. Registered; holds the current job length.
- v_obs_in  out  2  to core obs_in. Registered.
- v_obs_valid  out  1  to core obs_valid. Registered.
- v_done  in  1  from core done.
- v_path  in  16  from core; path_k is on bits [2k+1:2k] (integrator concatenates).
- m_path  out  16  decoded path; entries k>=m_len are 0.
- m_len  out  3  job length, 1..7.
- m_flags  out  2  bit0 = truncated, bit1 = bad symbol seen.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted when m_valid&&m_ready.
- jobs_done  out  CNTW  completed-result counter; wraps.

## Operation
Collector FSM (COLLECT, FULL, DISCARD):
- COLLECT:
  - s_ready=1. Each handshake writes buf[cnt]=s_obs and increments cnt.
  - s_obs==3 is stored as 0 and sets the bad flag.
  - s_last: go to FULL with len=cnt+1.
  - 7th symbol without s_last: set the trunc flag, go to DISCARD, len=7.
- DISCARD: s_ready=1. Symbols are dropped until the handshake carrying s_last, then go to FULL.
- FULL: s_ready=0. Returns to COLLECT (cnt=0, flags cleared) in the cycle after the sequencer issues the last symbol.

Sequencer FSM (S_IDLE, S_FEED, S_WAIT, S_DRAIN):
- S_IDLE:
  - Issue condition: collector FULL && m_valid==0 && v_done==0.
  - On issue, register v_start=1, v_obs_in=buf[0], v_length=len.
  - If len==1, release the buffer and go to S_WAIT; otherwise go to S_FEED with idx=1.
- S_FEED:
  - Registers v_obs_valid=1 with v_obs_in=buf[idx] on consecutive cycles, idx=1..len-1, with no gaps.
  - Releases the buffer and goes to S_WAIT after idx=len-1.
- S_WAIT:
  - On the first cycle v_done==1: m_path <= v_path masked to len entries, m_len <= len, m_flags <= job flags, m_valid <= 1, jobs_done++.
  - Then go to S_DRAIN.
- S_DRAIN: v_start is held 0 so the core leaves DONE. Return to S_IDLE when v_done==0.
- v_start and v_obs_valid are 1-cycle pulses, 0 otherwise. v_obs_in and v_length hold their last values.

Result port:
- m_valid stays high until m_ready; m_path, m_len and m_flags are stable while m_valid is high.
- The next job is not started while m_valid==1.
- Collection of the next job overlaps the core's decode of the current job.

## Timing
- Reset values:
  - s_ready=1; all v_* outputs 0.
  - m_path=0, m_len=0, m_flags=0, m_valid=0, jobs_done=0.
  - Both FSMs in their first state; cnt=0.
- The s_last handshake occurs in cycle c.
- v_start is high in cycle c+2 if the issue condition holds; later otherwise.
- With v_start high in cycle T:
  - v_obs_valid is high in T+1..T+len-1.
  - The core asserts done from T+2·len+1.
  - m_valid rises in T+2·len+2.
- s_ready returns to 1 in cycle T+len, or T+1 for len==1.
- Core done is high for 2 cycles. Capture happens exactly once per job.
- Simultaneous m_ready and a pending issue: issue is evaluated on registered m_valid, so start occurs one cycle after m_valid falls.
- Reset mid-job: all state is discarded, no result is produced, and the core is reset by the same rst_n.

## Test plan
Setup for all scenarios: logA=0, logC=0, logB diagonal=0 and off-diagonal=-100, so the decoded path equals the observations.
- Sequence 2,0,1,1 (last on the 4th symbol) -> m_len=4, m_path=16'h0052, m_flags=0, m_valid exactly 10 cycles after v_start, jobs_done=1.
- Single symbol 2 with last -> v_start with no v_obs_valid pulses, m_len=1, m_path=16'h0002, m_valid 4 cycles after v_start.
- 9 symbols of 1 with last on the 9th -> s_ready stays 1, m_len=7, m_path=16'h1555, m_flags=2'b01; symbols 8 and 9 dropped.
- Sequence 3,1 -> m_path=16'h0004, m_flags=2'b10.
- Two back-to-back 3-symbol jobs with m_ready=0 for 20 cycles -> second job collected, no second v_start until 1 cycle after the first result's handshake, results in order.
- rst_n low during S_FEED -> all outputs at reset values, next job decodes correctly.
